pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the per-stage enable, flush and bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves load-use hazards, taken-branch squashes and multi-cycle data-memory accesses, and keeps a saturating stall-cycle counter. It sits beside the datapath, observing decode/EX/MEM fields and the data-memory handshake.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max cycles spent in MEM_WAIT before declaring a memory fault (≥2).
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs of instruction in ID.
- id_rt  in  5  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_MemRead  in  1  instruction in EX is a load.
- ex_rt  in  5  load destination register in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_MemRead  in  1  load in MEM stage.
- mem_MemWrite  in  1  store in MEM stage.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load a NOP/bubble instead of the incoming stage data.
- memwb_bubble  out  1  MEM_WB captures RegWrite=0, MemtoReg=0 and MemRead=0.
- dmem_req  out  1  data-memory access request.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.
- mem_fault  out  1  sticky timeout flag.

## Operation
- States: RUN, MEM_WAIT, FAULT. Enable, flush and request outputs are combinational from the state and the current inputs. State, counters and mem_fault are registered.
- mem_acc = mem_MemRead | mem_MemWrite.
- dmem_req = mem_acc in RUN and MEM_WAIT; it is 0 in FAULT.
- load_use = ex_MemRead & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).

Action priority per cycle: memory stall > branch flush > load-use > normal.

- **Memory stall** (RUN or MEM_WAIT, mem_acc & ~dmem_ready):
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - memwb_en = 1 and memwb_bubble = 1.
  - RUN→MEM_WAIT.
- **Memory completes** (MEM_WAIT, dmem_ready):
  - All enables are 1; branch and load-use actions are evaluated normally this cycle.
  - Next state is RUN.
- **Branch flush** (ex_branch_taken):
  - All enables 1, ifid_flush = idex_flush = 1.
  - A simultaneous load-use is ignored because the ID instruction is squashed.
- **Load-use:**
  - pc_en = ifid_en = 0, idex_en = 1, idex_flush = 1.
  - exmem_en = memwb_en = 1.
  - This lasts exactly one cycle, because the load has moved to MEM by the next cycle.
- **Normal:** all enables 1; flushes and bubble 0.
- **Timeout:** a wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle. If it equals MEM_TIMEOUT-1 with dmem_ready=0, the next state is FAULT and mem_fault is set.
- **FAULT:**
  - All enables 0, flushes 0, dmem_req 0.
  - Held until reset.
- **stall_cnt:** increments on every posedge where pc_en=0 (including FAULT) and saturates at all-ones.
- **Reset (asserted at any time, including mid-wait):**
  - state=RUN, wait counter=0, stall_cnt=0, mem_fault=0.
  - While rst_n=0, all enables, flushes, memwb_bubble and dmem_req are 0.

## Timing
- Zero-latency control: outputs respond combinationally in the same cycle as their inputs.
- dmem_ready=1 in the first MEM cycle gives zero stall cycles.
- An access with N wait cycles produces N frozen cycles and N MEM_WB bubbles. The data is captured in the cycle dmem_ready=1.
- A branch taken while a memory stall is active is deferred. EX is held, so ex_branch_taken persists and is acted on in the release cycle.
- The fault is entered at the posedge after the MEM_TIMEOUT-th consecutive MEM_WAIT cycle without ready.
- Reset is asynchronous assert and synchronous-safe deassert. Outputs are valid from the first posedge after rst_n rises.

## Structure
- Package pipe_pkg holds:
  - state encodings ST_RUN=2'd0, ST_WAIT=2'd1, ST_FAULT=2'd2;
  - the register-zero constant REG_ZERO=5'd0;
  - default parameter values.
- Sub-module pipe_hazard_detect is the purely combinational load_use compare. It is instantiated once.
- Everything else lives in pipe_ctrl: the FSM, the wait counter and stall_cnt.

## Test plan
- **Load-use:** ex_MemRead=1, ex_rt=5, id_rs=5. Required: pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt 0→1.
- **Register-zero guard:** ex_rt=0, id_rs=0, ex_MemRead=1. Required: no stall, all enables 1.
- **Branch over load-use:** ex_branch_taken=1 together with a load-use match. Required: ifid_flush=idex_flush=1, pc_en=1, stall_cnt unchanged.
- **Memory wait:** mem_MemRead=1, dmem_ready low for 3 cycles and then high. Required:
  - 3 cycles of pc_en=0 and memwb_bubble=1;
  - release in the 4th cycle;
  - stall_cnt=3;
  - state back to RUN.
- **Timeout:** MEM_TIMEOUT=4, mem_MemWrite=1, dmem_ready held 0. Required: mem_fault=1 after 5 posedges; all enables 0 and dmem_req=0 thereafter.
- **Reset mid-wait:** rst_n pulsed low during MEM_WAIT. Required: outputs go to 0 immediately; stall_cnt=0; state RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline sequencing controller.
// Holds FSM state encodings, the register-zero constant and default parameter values.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 64;
  localparam int         CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> sequencing controller bundle: hazard fields in, stage controls out.
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
  parameter int CNT_W = pipe_pkg::CNT_W_DEF
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_MemRead;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             mem_MemRead;
  logic             mem_MemWrite;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             dmem_req;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_fault;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, ex_branch_taken,
           mem_MemRead, mem_MemWrite, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_bubble, dmem_req, stall_cnt, mem_fault
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, ex_branch_taken,
           mem_MemRead, mem_MemWrite, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_bubble, dmem_req, stall_cnt, mem_fault
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
// Purely combinational, zero latency; no backpressure of its own.
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  // $zero is never a real dependency, so a load targeting it must not stall.
  assign load_use_o = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
                      ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage enable/flush/bubble sequencing for the 5-stage core; controls are same-cycle combinational.
// A pending data-memory access freezes PC..EX_MEM and bubbles MEM_WB until dmem_ready; timeout latches FAULT.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_ctrl_if.master  bus
);

  localparam int              WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             fault_q, fault_d;

  logic mem_acc, mem_stall, load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_bubble, dmem_req;

  pipe_hazard_detect u_hazard (
    .ex_mem_read_i (bus.ex_MemRead),
    .ex_rt_i       (bus.ex_rt),
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rt_i  (bus.id_uses_rt),
    .load_use_o    (load_use)
  );

  assign mem_acc   = bus.mem_MemRead | bus.mem_MemWrite;
  assign mem_stall = mem_acc & ~bus.dmem_ready;

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;
    if (rst_n && (state_q != ST_FAULT)) begin
      dmem_req = mem_acc;
      if (mem_stall) begin
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        // A taken branch squashes the ID instruction, so its load-use is moot.
        if (bus.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    stall_d = stall_q;
    if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
          wait_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RUN;
        end else if (wait_q == WC_LAST) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.dmem_req     = dmem_req;
  assign bus.stall_cnt    = stall_q;
  assign bus.mem_fault    = fault_q;

endmodule
